// File: rtl/ct_spsram_param_memshade.sv
// ct_spsram_param_memshade: parametrised single-port SRAM with per-bit taint shadow and post-reset shadow sweep.
// Define MEMSHADE_DATA_CLEAR_EN to make the init sweep also zero the data array.
module ct_spsram_param_memshade #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int WE_WIDTH   = 32,
    parameter int OUT_REG    = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [ADDR_WIDTH-1:0] A_t0,
    input  logic                  CEN,
    input  logic                  CEN_t0,
    input  logic                  GWEN,
    input  logic                  GWEN_t0,
    input  logic [WE_WIDTH-1:0]   WEN,
    input  logic [WE_WIDTH-1:0]   WEN_t0,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] D_t0,
    output logic [DATA_WIDTH-1:0] Q,
    output logic [DATA_WIDTH-1:0] Q_t0,
    output logic                  BUSY
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LW = DATA_WIDTH / WE_WIDTH;
    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] sh [DEPTH];
    logic [DATA_WIDTH-1:0] s1, s1_t, s2, s2_t;
    logic rd_d, run, wr, rd, ctl_t;

    assign run = state == RUN;
    assign wr = run && !CEN && !GWEN;
    assign rd = run && !CEN && GWEN;
    assign ctl_t = |A_t0 | CEN_t0 | GWEN_t0;
    assign BUSY = !run;
    assign Q = OUT_REG != 0 ? s2 : s1;
    assign Q_t0 = OUT_REG != 0 ? s2_t : s1_t;

    // DEPTH is a power of two, so the counter is all-ones on the last sweep entry
    always_comb begin
        state_nxt = (!run && &cnt) ? RUN : state;
        cnt_nxt = run ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= INIT;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
        end
    end

    // A tainted write-enable on a read cannot prove no write happened, so its lanes become tainted
    always_ff @(posedge CLK) begin
        if (!RST && !run) begin
            sh[cnt] <= '0;
`ifdef MEMSHADE_DATA_CLEAR_EN
            mem[cnt] <= '0;
`endif
        end
        for (int i = 0; i < WE_WIDTH; i++) begin
            if (!RST && wr && !WEN[i]) begin
                mem[A][i*LW +: LW] <= D[i*LW +: LW];
                sh[A][i*LW +: LW] <= D_t0[i*LW +: LW] | {LW{WEN_t0[i] | ctl_t}};
            end
            if (!RST && rd && WEN_t0[i])
                sh[A][i*LW +: LW] <= '1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= '0;
            s1_t <= '0;
            s2 <= '0;
            s2_t <= '0;
            rd_d <= 1'b0;
        end else begin
            rd_d <= rd;
            if (rd) begin
                s1 <= mem[A];
                s1_t <= sh[A] | {DATA_WIDTH{ctl_t}};
            end
            if (rd_d) begin
                s2 <= s1;
                s2_t <= s1_t;
            end
        end
    end
endmodule

// File: tb/tb_ct_spsram_param_memshade.sv
// tb_ct_spsram_param_memshade: scoreboard bench driving a latency-1 and a latency-2 instance in lockstep.
module tb_ct_spsram_param_memshade;
    localparam int AW = 11, DW = 32, WW = 4, LW = DW / WW, DEPTH = 2 ** AW;
    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] at;
        logic [WW-1:0] wt;
        logic          ct;
    } rd_op_t;
    logic clk, rst, cen, cen_t, gwen, gwen_t;
    logic [AW-1:0] a, a_t;
    logic [WW-1:0] wen, wen_t;
    logic [DW-1:0] d, d_t, q0, q0_t, q1, q1_t;
    logic busy0, busy1;
    int checks, errors, n;
    logic [DW-1:0] mdl [int];
    logic [DW-1:0] mdl_t [int];
    logic [2*DW-1:0] sb0 [$];
    logic [2*DW-1:0] sb1 [$];
    logic [2*DW-1:0] e;
    rd_op_t ops [$];

    ct_spsram_param_memshade #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW), .OUT_REG(0)) u0 (
        .CLK(clk), .RST(rst), .A(a), .A_t0(a_t), .CEN(cen), .CEN_t0(cen_t), .GWEN(gwen), .GWEN_t0(gwen_t),
        .WEN(wen), .WEN_t0(wen_t), .D(d), .D_t0(d_t), .Q(q0), .Q_t0(q0_t), .BUSY(busy0));
    ct_spsram_param_memshade #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW), .OUT_REG(1)) u1 (
        .CLK(clk), .RST(rst), .A(a), .A_t0(a_t), .CEN(cen), .CEN_t0(cen_t), .GWEN(gwen), .GWEN_t0(gwen_t),
        .WEN(wen), .WEN_t0(wen_t), .D(d), .D_t0(d_t), .Q(q1), .Q_t0(q1_t), .BUSY(busy1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        cen = 1'b1; gwen = 1'b1; wen = '1;
        cen_t = 1'b0; gwen_t = 1'b0; wen_t = '0; a_t = '0; d_t = '0;
    endtask

    task automatic issue_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [WW-1:0] we,
                               input logic [DW-1:0] dt, input logic [WW-1:0] wt, input logic gt);
        logic [DW-1:0] md, mt;
        md = mdl.exists(int'(addr)) ? mdl[int'(addr)] : 'x;
        mt = mdl_t.exists(int'(addr)) ? mdl_t[int'(addr)] : '0;
        for (int i = 0; i < WW; i++)
            if (!we[i]) begin
                md[i*LW +: LW] = data[i*LW +: LW];
                mt[i*LW +: LW] = dt[i*LW +: LW] | {LW{wt[i] | gt}};
            end
        mdl[int'(addr)] = md;
        mdl_t[int'(addr)] = mt;
        cen = 1'b0; gwen = 1'b0; a = addr; d = data; wen = we; d_t = dt; wen_t = wt; gwen_t = gt;
        @(negedge clk);
        idle();
    endtask

    task automatic issue_read(input rd_op_t op);
        logic [DW-1:0] mt;
        e = {mdl[int'(op.a)], mdl_t[int'(op.a)] | {DW{|op.at | op.ct}}};
        sb0.push_back(e);
        sb1.push_back(e);
        mt = mdl_t[int'(op.a)];
        for (int i = 0; i < WW; i++)
            if (op.wt[i]) mt[i*LW +: LW] = '1;
        mdl_t[int'(op.a)] = mt;
        cen = 1'b0; gwen = 1'b1; wen = '1; a = op.a; a_t = op.at; wen_t = op.wt; cen_t = op.ct;
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy0, busy1, q0, q0_t, q1, q1_t} !== {2'b11, {4*DW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_state busy=%b%b q0=%h/%h q1=%h/%h want busy=11 all zero", busy0, busy1, q0, q0_t, q1, q1_t);
        end
        rst = 1'b0; cen = 1'b0; gwen = 1'b0; wen = '0; a = 11'd5; d = 32'hDEADBEEF; d_t = '1;
        n = 0;
        while (busy0 === 1'b1 && n < 3 * DEPTH) begin
            @(negedge clk);
            n++;
            if (n == 1) begin gwen = 1'b1; wen = '1; d_t = '0; end
            if (n == 2) idle();
            if (n == 10) begin
                checks++;
                if ({q0, q0_t, q1, q1_t} !== '0) begin
                    errors++;
                    $display("FAIL busy_q_hold q0=%h/%h q1=%h/%h want 0", q0, q0_t, q1, q1_t);
                end
            end
        end
        checks++;
        if (n != DEPTH || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL busy_len got %0d busy1=%b want %0d busy1=0", n, busy1, DEPTH);
        end
        cen = 1'b0; gwen = 1'b1; a = 11'd5;
        @(negedge clk);
        idle();
        checks++;
`ifdef MEMSHADE_DATA_CLEAR_EN
        if (q0 !== '0 || q0_t !== '0) begin
`else
        if (q0 === 32'hDEADBEEF || q0_t !== '0) begin
`endif
            errors++;
            $display("FAIL busy_write_ignored q0=%h q0_t=%h want data not DEADBEEF, taint 0", q0, q0_t);
        end
    endtask

    task automatic test_write_read();
        issue_write(11'h10, 32'hDEADBEEF, '0, 32'h000000FF, '0, 1'b0);
        ops.delete();
        ops.push_back('{11'h10, '0, '0, 1'b0});
        ops.push_back('{11'h10, '0, '0, 1'b0});
        foreach (ops[k]) begin
            issue_read(ops[k]);
            e = sb0.pop_front(); checks++;
            if ({q0, q0_t} !== e) begin errors++; $display("FAIL wr_rd_q0 k=%0d got %h/%h want %h/%h", k, q0, q0_t, e[2*DW-1:DW], e[DW-1:0]); end
            if (k > 0) begin
                e = sb1.pop_front(); checks++;
                if ({q1, q1_t} !== e) begin errors++; $display("FAIL wr_rd_q1 k=%0d got %h/%h want %h/%h", k, q1, q1_t, e[2*DW-1:DW], e[DW-1:0]); end
            end
        end
        @(negedge clk);
        e = sb1.pop_front(); checks++;
        if ({q1, q1_t} !== {32'hDEADBEEF, 32'h000000FF}) begin errors++; $display("FAIL wr_rd_q1_last got %h/%h want deadbeef/000000ff", q1, q1_t); end
    endtask

    task automatic test_lanes();
        issue_write(11'h20, 32'h11223344, '0, 32'h0000FF00, '0, 1'b0);
        issue_write(11'h20, 32'hAABBCCDD, 4'b1010, '0, '0, 1'b0);
        issue_read('{11'h20, '0, '0, 1'b0});
        e = sb0.pop_front(); checks++;
        if ({q0, q0_t} !== {32'h11BB33DD, 32'h0000FF00}) begin errors++; $display("FAIL lane_q0 got %h/%h want 11bb33dd/0000ff00", q0, q0_t); end
        @(negedge clk);
        e = sb1.pop_front(); checks++;
        if ({q1, q1_t} !== e) begin errors++; $display("FAIL lane_q1 got %h/%h want %h/%h", q1, q1_t, e[2*DW-1:DW], e[DW-1:0]); end
    endtask

    task automatic test_taint();
        issue_write(11'h3, 32'h00000055, '0, '0, '0, 1'b0);
        issue_write(11'h30, 32'h0, '0, '0, 4'b0001, 1'b0);
        issue_write(11'h31, 32'hCAFEF00D, '0, '0, '0, 1'b0);
        issue_write(11'h31, 32'h12345678, 4'b1100, '0, '0, 1'b1);
        ops.delete();
        ops.push_back('{11'h3, 11'h001, '0, 1'b0});
        ops.push_back('{11'h30, '0, 4'b0100, 1'b0});
        ops.push_back('{11'h30, '0, '0, 1'b0});
        ops.push_back('{11'h31, '0, '0, 1'b0});
        ops.push_back('{11'h31, '0, '0, 1'b1});
        foreach (ops[k]) begin
            issue_read(ops[k]);
            e = sb0.pop_front(); checks++;
            if ({q0, q0_t} !== e) begin errors++; $display("FAIL taint_q0 k=%0d got %h/%h want %h/%h", k, q0, q0_t, e[2*DW-1:DW], e[DW-1:0]); end
            if (k > 0) begin
                e = sb1.pop_front(); checks++;
                if ({q1, q1_t} !== e) begin errors++; $display("FAIL taint_q1 k=%0d got %h/%h want %h/%h", k, q1, q1_t, e[2*DW-1:DW], e[DW-1:0]); end
            end
        end
        @(negedge clk);
        e = sb1.pop_front(); checks++;
        if ({q1, q1_t} !== e) begin errors++; $display("FAIL taint_q1_last got %h/%h want %h/%h", q1, q1_t, e[2*DW-1:DW], e[DW-1:0]); end
    endtask

    task automatic test_back_to_back();
        ops.delete();
        for (int k = 0; k < 6; k++) begin
            issue_write(AW'(11'h100 + k), $urandom, '0, $urandom, '0, 1'b0);
            ops.push_back('{AW'(11'h100 + k), '0, '0, 1'b0});
        end
        foreach (ops[k]) begin
            issue_read(ops[k]);
            e = sb0.pop_front(); checks++;
            if ({q0, q0_t} !== e) begin errors++; $display("FAIL b2b_q0 k=%0d got %h/%h want %h/%h", k, q0, q0_t, e[2*DW-1:DW], e[DW-1:0]); end
            if (k > 0) begin
                e = sb1.pop_front(); checks++;
                if ({q1, q1_t} !== e) begin errors++; $display("FAIL b2b_q1 k=%0d got %h/%h want %h/%h", k, q1, q1_t, e[2*DW-1:DW], e[DW-1:0]); end
            end
        end
        @(negedge clk);
        e = sb1.pop_front(); checks++;
        if ({q1, q1_t} !== e) begin errors++; $display("FAIL b2b_q1_last got %h/%h want %h/%h", q1, q1_t, e[2*DW-1:DW], e[DW-1:0]); end
    endtask

    task automatic test_hold();
        issue_write(11'h40, 32'h00001234, '0, '0, '0, 1'b0);
        issue_read('{11'h40, '0, '0, 1'b0});
        e = sb0.pop_front();
        void'(sb1.pop_front());
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if ({q0, q0_t, q1, q1_t} !== {2{32'h00001234, 32'h0}}) begin
                errors++;
                $display("FAIL hold k=%0d q0=%h/%h q1=%h/%h want 00001234/0", k, q0, q0_t, q1, q1_t);
            end
        end
    endtask

    task automatic test_mid_init_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (busy0 === 1'b1 && n < 3 * DEPTH) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != DEPTH || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_init_busy_len got %0d busy1=%b want %0d", n, busy1, DEPTH);
        end
        cen = 1'b0; gwen = 1'b1; a = 11'h10;
        @(negedge clk);
        idle();
        @(negedge clk);
        checks++;
`ifdef MEMSHADE_DATA_CLEAR_EN
        if ({q0, q0_t, q1, q1_t} !== '0) begin
`else
        if ({q0, q0_t, q1, q1_t} !== {mdl[16], 32'h0, mdl[16], 32'h0}) begin
`endif
            errors++;
            $display("FAIL post_reset_read q0=%h/%h q1=%h/%h", q0, q0_t, q1, q1_t);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        a = '0; d = '0;
        test_reset();
        test_write_read();
        test_lanes();
        test_taint();
        test_back_to_back();
        test_hold();
        test_mid_init_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
